// File: rtl/issue_rename.sv
// -----------------------------------------------------------------------------
// issue_rename
//
// Register-renaming issue stage for a Tomasulo-style core. Each accepted
// instruction reads its source operands from the architectural register file
// or from the producer tags in the status table. If the instruction writes a
// destination register, it is given a free tag. The resolved entry is held in
// a one-deep dispatch register until the reservation station takes it. While
// it waits there, the entry captures any matching common-data-bus (CDB)
// results.
//
// Ports
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   flush                  squash all in-flight rename state
//   in_valid / in_ready    decoded-instruction handshake
//   in_rs1/in_rs2/in_rd    architectural register numbers
//   in_use1/in_use2/in_wr  source-read and destination-write enables
//   in_imm, in_Op          immediate and operation code, passed through
//   out_valid / out_ready  dispatch-entry handshake
//   out_Op, out_imm        registered pass-through fields
//   out_Vj/out_Vk          operand values, meaningful when matching Q is 0
//   out_Qj/out_Qk          producer tags, 0 = value ready
//   out_tag                destination tag, 0 when no register is written
//   cdb_valid/tag/data     CDB_N broadcast ports, port i at slice i
// -----------------------------------------------------------------------------
module issue_rename #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4,
   parameter int CDB_N = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [4:0]              in_rs1,
   input  logic [4:0]              in_rs2,
   input  logic [4:0]              in_rd,
   input  logic                    in_use1,
   input  logic                    in_use2,
   input  logic                    in_wr,
   input  logic [XLEN-1:0]         in_imm,
   input  logic [9:0]              in_Op,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [9:0]              out_Op,
   output logic [XLEN-1:0]         out_imm,
   output logic [XLEN-1:0]         out_Vj,
   output logic [XLEN-1:0]         out_Vk,
   output logic [TAG_W-1:0]        out_Qj,
   output logic [TAG_W-1:0]        out_Qk,
   output logic [TAG_W-1:0]        out_tag,
   input  logic [CDB_N-1:0]        cdb_valid,
   input  logic [CDB_N*TAG_W-1:0]  cdb_tag,
   input  logic [CDB_N*XLEN-1:0]   cdb_data
);

   localparam int NTAG = 1 << TAG_W;

   typedef logic [TAG_W-1:0] tag_t;
   typedef logic [XLEN-1:0]  word_t;

   typedef struct packed {
      logic  hit;
      word_t data;
   } cdb_hit_t;

   typedef struct packed {
      word_t v;
      tag_t  q;
   } opnd_t;

   // Searches the CDB for a valid broadcast of 'tag'. The scan runs from the
   // highest port down, so the lowest matching port index ends up supplying
   // the data. Tag 0 means "ready" and never matches.
   function automatic cdb_hit_t cdb_match(
      input tag_t                   tag,
      input logic [CDB_N-1:0]       v,
      input logic [CDB_N*TAG_W-1:0] t,
      input logic [CDB_N*XLEN-1:0]  d
   );
      cdb_hit_t r;
      r = '0;
      for (int i = CDB_N - 1; i >= 0; i--) begin
         if (v[i] && (tag != '0) && (t[i*TAG_W +: TAG_W] == tag)) begin
            r.hit  = 1'b1;
            r.data = d[i*XLEN +: XLEN];
         end
      end
      return r;
   endfunction

   // Resolves one source operand against the pre-rename status. A result
   // broadcast this same cycle is forwarded, so the entry never waits on a
   // tag that is already retiring.
   function automatic opnd_t resolve(
      input logic       use_s,
      input logic [4:0] rs,
      input logic       busy,
      input tag_t       tag,
      input word_t      rval,
      input cdb_hit_t   h
   );
      opnd_t r;
      r = '0;
      if (use_s && (rs != 5'd0)) begin
         if (!busy)      r.v = rval;
         else if (h.hit) r.v = h.data;
         else            r.q = tag;
      end
      return r;
   endfunction

   // Architectural state
   word_t           regfile_q [32];
   word_t           regfile_d [32];
   logic [31:0]     busy_q, busy_d;
   tag_t            stag_q [32];
   tag_t            stag_d [32];
   logic [NTAG-1:0] free_q, free_d;

   // Dispatch register
   logic            out_valid_q, out_valid_d;
   logic [9:0]      out_op_q, out_op_d;
   word_t           out_imm_q, out_imm_d;
   word_t           out_vj_q, out_vj_d;
   word_t           out_vk_q, out_vk_d;
   tag_t            out_qj_q, out_qj_d;
   tag_t            out_qk_q, out_qk_d;
   tag_t            out_tag_q, out_tag_d;

   // Combinational helpers
   cdb_hit_t        wb_hit [32];
   cdb_hit_t        snoop_j, snoop_k;
   opnd_t           src1, src2;
   tag_t            alloc_tag;
   logic            any_free;
   logic            accept;
   logic            do_rename;

   // Bit 0 of the free bitmap is never set, so it cannot affect the OR.
   assign any_free  = |free_q;
   assign in_ready  = !flush && (!out_valid_q || out_ready) &&
                      (!in_wr || (in_rd == 5'd0) || any_free);
   assign accept    = in_valid && in_ready;
   assign do_rename = accept && in_wr && (in_rd != 5'd0);

   // Lowest free tag. The scan uses only the registered bitmap, so a tag
   // that the CDB frees this cycle can be allocated from the next cycle on.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch;
      // a path that leaves one unassigned would infer a latch.
      alloc_tag = '0;
      for (int i = NTAG - 1; i >= 1; i--) begin
         if (free_q[i]) alloc_tag = tag_t'(i);
      end
   end

   always_comb begin
      for (int r = 0; r < 32; r++) begin
         wb_hit[r] = cdb_match(stag_q[r], cdb_valid, cdb_tag, cdb_data);
      end
      snoop_j = cdb_match(out_qj_q, cdb_valid, cdb_tag, cdb_data);
      snoop_k = cdb_match(out_qk_q, cdb_valid, cdb_tag, cdb_data);
      src1 = resolve(in_use1, in_rs1, busy_q[in_rs1], stag_q[in_rs1],
                     regfile_q[in_rs1], wb_hit[in_rs1]);
      src2 = resolve(in_use2, in_rs2, busy_q[in_rs2], stag_q[in_rs2],
                     regfile_q[in_rs2], wb_hit[in_rs2]);
   end

   // Next state of the rename tables
   always_comb begin
      regfile_d = regfile_q;
      busy_d    = busy_q;
      stag_d    = stag_q;
      free_d    = free_q;

      if (flush) begin
         // The register file keeps its contents. Producers are dropped, and
         // CDB results broadcast in this cycle are discarded.
         busy_d = '0;
         free_d = {{(NTAG-1){1'b1}}, 1'b0};
      end else begin
         for (int i = 0; i < CDB_N; i++) begin
            if (cdb_valid[i] && (cdb_tag[i*TAG_W +: TAG_W] != '0)) begin
               free_d[cdb_tag[i*TAG_W +: TAG_W]] = 1'b1;
            end
         end
         for (int r = 1; r < 32; r++) begin
            if (busy_q[r] && wb_hit[r].hit) begin
               regfile_d[r] = wb_hit[r].data;
               busy_d[r]    = 1'b0;
            end
         end
         // A rename of the same register overrides its writeback. The older
         // value is stale once a younger producer exists.
         if (do_rename) begin
            free_d[alloc_tag] = 1'b0;
            busy_d[in_rd]     = 1'b1;
            stag_d[in_rd]     = alloc_tag;
            regfile_d[in_rd]  = regfile_q[in_rd];
         end
      end
   end

   // Next state of the dispatch register
   always_comb begin
      out_valid_d = out_valid_q;
      out_op_d    = out_op_q;
      out_imm_d   = out_imm_q;
      out_vj_d    = out_vj_q;
      out_vk_d    = out_vk_q;
      out_qj_d    = out_qj_q;
      out_qk_d    = out_qk_q;
      out_tag_d   = out_tag_q;

      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         out_op_d    = in_Op;
         out_imm_d   = in_imm;
         out_vj_d    = src1.v;
         out_qj_d    = src1.q;
         out_vk_d    = src2.v;
         out_qk_d    = src2.q;
         out_tag_d   = do_rename ? alloc_tag : '0;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end else if (out_valid_q) begin
         // A stalled entry captures results that arrive while it waits.
         if (snoop_j.hit) begin
            out_vj_d = snoop_j.data;
            out_qj_d = '0;
         end
         if (snoop_k.hit) begin
            out_vk_d = snoop_k.data;
            out_qk_d = '0;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments only, so every flop
   // samples its pre-edge value regardless of process ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the register file has a reset here on purpose. After reset,
         // software observes every register as zero, so it cannot be left as
         // an uninitialised RAM.
         for (int r = 0; r < 32; r++) begin
            regfile_q[r] <= '0;
            stag_q[r]    <= '0;
         end
         busy_q      <= '0;
         free_q      <= {{(NTAG-1){1'b1}}, 1'b0};
         out_valid_q <= 1'b0;
         out_op_q    <= '0;
         out_imm_q   <= '0;
         out_vj_q    <= '0;
         out_vk_q    <= '0;
         out_qj_q    <= '0;
         out_qk_q    <= '0;
         out_tag_q   <= '0;
      end else begin
         regfile_q   <= regfile_d;
         stag_q      <= stag_d;
         busy_q      <= busy_d;
         free_q      <= free_d;
         out_valid_q <= out_valid_d;
         out_op_q    <= out_op_d;
         out_imm_q   <= out_imm_d;
         out_vj_q    <= out_vj_d;
         out_vk_q    <= out_vk_d;
         out_qj_q    <= out_qj_d;
         out_qk_q    <= out_qk_d;
         out_tag_q   <= out_tag_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_Op    = out_op_q;
   assign out_imm   = out_imm_q;
   assign out_Vj    = out_vj_q;
   assign out_Vk    = out_vk_q;
   assign out_Qj    = out_qj_q;
   assign out_Qk    = out_qk_q;
   assign out_tag   = out_tag_q;

endmodule

// File: doc/issue_rename.md
ISSUE_RENAME -- requirements
Module: issue_rename

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/data width.
REQ-002 SHALL have parameter TAG_W, default 4: tag width; tag 0 means "value ready", tags 1..2^TAG_W-1 allocatable.
REQ-003 SHALL have parameter CDB_N, default 2: number of common-data-bus broadcast ports.
REQ-004 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  squash all in-flight state
- in_valid  in  1  decoded instruction offered
- in_ready  out  1  instruction accepted this cycle when high with in_valid
- in_rs1, in_rs2, in_rd  in  5 each  architectural register numbers
- in_use1, in_use2, in_wr  in  1 each  rs1 read, rs2 read, rd written
- in_imm  in  XLEN  immediate
- in_Op  in  10  operation code
- out_valid  out  1  dispatch entry valid
- out_ready  in  1  reservation station accepts entry
- out_Op  out  10; out_imm  out  XLEN
- out_Vj, out_Vk  out  XLEN  operand values, meaningful when matching Q is 0
- out_Qj, out_Qk  out  TAG_W  producer tags, 0 = ready
- out_tag  out  TAG_W  destination tag, 0 if no rd write
- cdb_valid  in  CDB_N; cdb_tag  in  CDB_N*TAG_W; cdb_data  in  CDB_N*XLEN  broadcast results, port i at slice i

Function
REQ-005 SHALL hold a 32 x XLEN register file and a 32-entry status table (busy bit + TAG_W tag); x0 never busy, always reads 0.
REQ-006 SHALL hold a free bitmap of allocatable tags.
REQ-007 SHALL drive in_ready = !flush && (!out_valid || out_ready) && (!in_wr || in_rd==0 || any tag free).
REQ-008 On accept with in_wr and in_rd!=0, SHALL allocate the lowest-numbered free tag, clear its free bit, and set status[in_rd] = busy with that tag at the clock edge.
REQ-009 Operand lookup per source (if in_useN=0: V=0, Q=0): not busy -> V=regfile, Q=0; busy and a valid CDB port carries the status tag this cycle -> V=that port's data, Q=0; else V=0, Q=status tag.
REQ-010 Source lookup SHALL use status before this instruction's rename (rs1==rd reads old producer).
REQ-011 Accepted entry SHALL appear on out_* with out_valid=1 the cycle after acceptance (1-cycle latency).
REQ-012 While out_valid=1 and not taken, SHALL snoop CDB each cycle: Qj/Qk matching a valid port tag -> capture data into Vj/Vk, clear Q.
REQ-013 out_valid SHALL clear after out_valid&&out_ready unless a new instruction is accepted in the same cycle (back-to-back at full rate).
REQ-014 For each valid CDB port: tag's free bit SHALL set; every register whose busy tag equals it SHALL be written with the data and cleared not busy.
REQ-015 CDB write and rename of the same rd in one cycle: rename wins; status holds new tag, register file unchanged by the CDB.
REQ-016 A tag freed by CDB SHALL not be allocatable until the following cycle.
REQ-017 Multiple CDB ports with the same valid tag: lowest port index supplies data.
REQ-018 flush SHALL, at the edge: clear all busy bits, free all tags, clear out_valid; register file contents retained; CDB updates that cycle ignored.

Reset
REQ-019 Reset SHALL asynchronously clear register file, status table, out_valid and all out_* fields to 0, and mark all tags free.
REQ-020 First accept after reset deassertion SHALL receive tag 1.

Verification
REQ-021 After reset, issue rd=x5 with out_ready=1 -> next cycle out_valid=1, out_tag=1, status x5 busy tag 1.
REQ-022 Issue rs1=x5 while x5 busy tag 1, no CDB -> out_Qj=1; hold out_ready=0, broadcast tag 1 data 0x1234 -> following cycle out_Qj=0, out_Vj=0x1234, x5 reads 0x1234.
REQ-023 Same-cycle CDB tag 1 data 0xAA and issue rs1=x5 (busy tag 1) -> out_Qj=0, out_Vj=0xAA.
REQ-024 TAG_W=2: three rd-writes outstanding (tags 1..3) -> in_ready=0 for rd-writing instr, in_ready=1 for in_wr=0; CDB tag 2 -> tag 2 allocated no earlier than next cycle.
REQ-025 CDB tag 1 for x5 while issuing new rd=x5 same cycle -> x5 busy with new tag, x5 register value unchanged.
REQ-026 flush with out_valid=1 and 3 busy registers -> next cycle out_valid=0, no busy registers, next allocation tag 1.
